// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the shared-memory arbiter.
// The arbiter uses the slave view; the CPU/memory side uses the master view.
interface mem_port_arbiter_if #(
  parameter int WORD_SIZE = 16
);
  logic                 i_readM;
  logic [WORD_SIZE-1:0] i_address;
  logic [WORD_SIZE-1:0] i_rdata;
  logic                 i_ready;

  logic                 d_readM;
  logic                 d_writeM;
  logic [WORD_SIZE-1:0] d_address;
  logic [WORD_SIZE-1:0] d_wdata;
  logic [WORD_SIZE-1:0] d_rdata;
  logic                 d_ready;

  logic                 mem_readM;
  logic                 mem_writeM;
  logic [WORD_SIZE-1:0] mem_address;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic [WORD_SIZE-1:0] mem_rdata;

  logic                 busy;
  logic [15:0]          num_conflicts;

  modport slave (
    input  i_readM, i_address,
    output i_rdata, i_ready,
    input  d_readM, d_writeM, d_address, d_wdata,
    output d_rdata, d_ready,
    output mem_readM, mem_writeM, mem_address, mem_wdata,
    input  mem_rdata,
    output busy, num_conflicts
  );

  modport master (
    output i_readM, i_address,
    input  i_rdata, i_ready,
    output d_readM, d_writeM, d_address, d_wdata,
    input  d_rdata, d_ready,
    input  mem_readM, mem_writeM, mem_address, mem_wdata,
    output mem_rdata,
    input  busy, num_conflicts
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Fixed-latency IDLE/ACCESS/RESP FSM, data priority with a fetch anti-starvation limit.
module mem_port_arbiter #(
  parameter int WORD_SIZE    = 16,
  parameter int LATENCY      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  mem_port_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int SC_W  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(LATENCY - 1);
  localparam logic [SC_W-1:0]  STARVE_MAX = SC_W'(STARVE_LIMIT);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [SC_W-1:0]  starve_cnt;
  logic             win_d;
  logic             op_write;

  logic d_req;
  logic grant_i;
  logic grant_d;
  logic conflict;

  // Fetch only beats a pending data request once it has been passed over STARVE_LIMIT times.
  always_comb begin
    d_req    = bus.d_readM | bus.d_writeM;
    grant_i  = bus.i_readM && (!d_req || (starve_cnt == STARVE_MAX));
    grant_d  = d_req && !grant_i;
    conflict = bus.i_readM && d_req;
  end

  assign bus.busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= ST_IDLE;
      cnt               <= '0;
      starve_cnt        <= '0;
      win_d             <= 1'b0;
      op_write          <= 1'b0;
      bus.mem_readM     <= 1'b0;
      bus.mem_writeM    <= 1'b0;
      bus.mem_address   <= '0;
      bus.mem_wdata     <= '0;
      bus.i_rdata       <= '0;
      bus.d_rdata       <= '0;
      bus.i_ready       <= 1'b0;
      bus.d_ready       <= 1'b0;
      bus.num_conflicts <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_i || grant_d) begin
            state           <= ST_ACCESS;
            cnt             <= CNT_LOAD;
            win_d           <= grant_d;
            // A simultaneous read+write on the data side is a write.
            op_write        <= grant_d && bus.d_writeM;
            bus.mem_readM   <= !(grant_d && bus.d_writeM);
            bus.mem_writeM  <= grant_d && bus.d_writeM;
            bus.mem_address <= grant_d ? bus.d_address : bus.i_address;
            bus.mem_wdata   <= grant_d ? bus.d_wdata : '0;
          end

          if (grant_i || !bus.i_readM) begin
            starve_cnt <= '0;
          end else if (grant_d) begin
            starve_cnt <= starve_cnt + 1'b1;
          end

          if (conflict && (bus.num_conflicts != 16'hFFFF)) begin
            bus.num_conflicts <= bus.num_conflicts + 16'd1;
          end
        end

        ST_ACCESS: begin
          if (cnt == '0) begin
            state          <= ST_RESP;
            bus.mem_readM  <= 1'b0;
            bus.mem_writeM <= 1'b0;
            if (!op_write) begin
              if (win_d) begin
                bus.d_rdata <= bus.mem_rdata;
              end else begin
                bus.i_rdata <= bus.mem_rdata;
              end
            end
            bus.d_ready <= win_d;
            bus.i_ready <= !win_d;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_RESP: begin
          state       <= ST_IDLE;
          bus.i_ready <= 1'b0;
          bus.d_ready <= 1'b0;
        end

        default: begin
          state          <= ST_IDLE;
          bus.mem_readM  <= 1'b0;
          bus.mem_writeM <= 1'b0;
          bus.i_ready    <= 1'b0;
          bus.d_ready    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table for single accesses plus
// hand-written reset, conflict and starvation sequences.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic clk;
  logic reset_n;

  mem_port_arbiter_if #(.WORD_SIZE(16)) bus ();

  mem_port_arbiter #(
    .WORD_SIZE    (16),
    .LATENCY      (LAT),
    .STARVE_LIMIT (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: one special word, everything else reads back the inverted address.
  always_comb begin
    bus.mem_rdata = (bus.mem_address == 16'h0010) ? 16'hA5A5 : ~bus.mem_address;
  end

  typedef struct {
    logic        i_rd;
    logic [15:0] i_addr;
    logic        d_rd;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wd;
    logic        exp_d_side;
    logic        exp_wr;
    logic [15:0] exp_addr;
    logic [15:0] exp_wdata;
    logic [15:0] exp_i_rdata;
    logic [15:0] exp_d_rdata;
  } vec_t;

  vec_t  vecs [7];
  int    checks;
  int    errors;
  string tag;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %h expected %h", tag, name, act, exp);
    end
  endtask

  task automatic drop_all();
    bus.i_readM  = 1'b0;
    bus.d_readM  = 1'b0;
    bus.d_writeM = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    tag    = "init";

    //            i_rd i_addr    d_rd d_wr d_addr    d_wd      dside wr  addr      wdata     i_rdata   d_rdata
    vecs[0] = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hA5A5, 16'h0000};
    vecs[1] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0040, 16'h1234, 1'b1, 1'b1, 16'h0040, 16'h1234, 16'hA5A5, 16'h0000};
    vecs[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0100, 16'h0000, 1'b1, 1'b0, 16'h0100, 16'h0000, 16'hA5A5, 16'hFEFF};
    vecs[3] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0200, 16'h5555, 1'b1, 1'b1, 16'h0200, 16'h5555, 16'hA5A5, 16'hFEFF};
    vecs[4] = '{1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h1234, 16'h0000, 16'hEDCB, 16'hFEFF};
    vecs[5] = '{1'b1, 16'h0300, 1'b1, 1'b0, 16'h0400, 16'h0000, 1'b1, 1'b0, 16'h0400, 16'h0000, 16'hEDCB, 16'hFBFF};
    vecs[6] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'hFFFF, 1'b1, 1'b1, 16'h0000, 16'hFFFF, 16'hEDCB, 16'hFBFF};

    drop_all();
    bus.i_address = '0;
    bus.d_address = '0;
    bus.d_wdata   = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    tag = "reset";
    chk("i_rdata",       bus.i_rdata, 0);
    chk("d_rdata",       bus.d_rdata, 0);
    chk("i_ready",       bus.i_ready, 0);
    chk("d_ready",       bus.d_ready, 0);
    chk("mem_readM",     bus.mem_readM, 0);
    chk("mem_writeM",    bus.mem_writeM, 0);
    chk("mem_address",   bus.mem_address, 0);
    chk("mem_wdata",     bus.mem_wdata, 0);
    chk("busy",          bus.busy, 0);
    chk("num_conflicts", bus.num_conflicts, 0);
    @(negedge clk) reset_n = 1'b1;

    // Reset pulsed during the first access cycle of a fetch.
    tag = "rst_mid";
    @(negedge clk);
    bus.i_readM   = 1'b1;
    bus.i_address = 16'h0010;
    @(posedge clk);
    @(negedge clk);
    chk("mem_readM_c1", bus.mem_readM, 1);
    reset_n = 1'b0;
    drop_all();
    #1;
    chk("mem_readM", bus.mem_readM, 0);
    chk("busy",      bus.busy, 0);
    chk("i_ready",   bus.i_ready, 0);
    chk("i_rdata",   bus.i_rdata, 0);
    @(negedge clk) reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("no_i_ready", bus.i_ready, 0);
      chk("idle_busy",  bus.busy, 0);
    end

    // Single accesses from the table.
    for (int i = 0; i < 7; i++) begin
      tag = $sformatf("vec%0d", i);
      bus.i_readM   = vecs[i].i_rd;
      bus.i_address = vecs[i].i_addr;
      bus.d_readM   = vecs[i].d_rd;
      bus.d_writeM  = vecs[i].d_wr;
      bus.d_address = vecs[i].d_addr;
      bus.d_wdata   = vecs[i].d_wd;
      for (int c = 1; c <= LAT + 1; c++) begin
        @(posedge clk);
        @(negedge clk);
        if (c <= LAT) begin
          chk("busy_access", bus.busy, 1);
          chk("mem_readM",   bus.mem_readM, !vecs[i].exp_wr);
          chk("mem_writeM",  bus.mem_writeM, vecs[i].exp_wr);
          chk("mem_address", bus.mem_address, vecs[i].exp_addr);
          if (vecs[i].exp_wr) chk("mem_wdata", bus.mem_wdata, vecs[i].exp_wdata);
          chk("early_ready", {bus.i_ready, bus.d_ready}, 0);
        end else begin
          chk("busy_resp",   bus.busy, 1);
          chk("i_ready",     bus.i_ready, !vecs[i].exp_d_side);
          chk("d_ready",     bus.d_ready, vecs[i].exp_d_side);
          chk("strobes_off", {bus.mem_readM, bus.mem_writeM}, 0);
          chk("i_rdata",     bus.i_rdata, vecs[i].exp_i_rdata);
          chk("d_rdata",     bus.d_rdata, vecs[i].exp_d_rdata);
          drop_all();
        end
      end
      @(posedge clk);
      @(negedge clk);
      chk("busy_idle",  bus.busy, 0);
      chk("ready_idle", {bus.i_ready, bus.d_ready}, 0);
    end
    tag = "table_end";
    chk("num_conflicts", bus.num_conflicts, 1);

    // Both sides at once: D first, I on the following IDLE.
    tag = "conflict";
    bus.i_readM   = 1'b1;
    bus.i_address = 16'h0010;
    bus.d_readM   = 1'b1;
    bus.d_address = 16'h0500;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("d_ready", bus.d_ready, (c == 3));
      chk("i_ready", bus.i_ready, (c == 7));
      if (c == 1) chk("starve_after_d", dut.starve_cnt, 1);
      if (c == 3) begin
        chk("d_rdata", bus.d_rdata, 16'hFAFF);
        bus.d_readM = 1'b0;
      end
      if (c == 5) chk("starve_after_i", dut.starve_cnt, 0);
      if (c == 7) begin
        chk("i_rdata", bus.i_rdata, 16'hA5A5);
        bus.i_readM = 1'b0;
      end
      if (c == 8) chk("busy_idle", bus.busy, 0);
    end
    chk("num_conflicts", bus.num_conflicts, 2);

    // Fetch held while data issues back-to-back: grants D, D, I, D.
    tag = "starve";
    bus.i_readM   = 1'b1;
    bus.i_address = 16'h0020;
    bus.d_readM   = 1'b1;
    bus.d_address = 16'h0030;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("d_ready", bus.d_ready, (c == 3) || (c == 7) || (c == 15));
      chk("i_ready", bus.i_ready, (c == 11));
      chk("ready_exclusive", bus.i_ready & bus.d_ready, 0);
      if (c == 5)  chk("starve_2", dut.starve_cnt, 2);
      if (c == 9)  chk("starve_0", dut.starve_cnt, 0);
      if (c == 13) chk("starve_1", dut.starve_cnt, 1);
      if (c == 3)  chk("d_rdata", bus.d_rdata, 16'hFFCF);
      if (c == 11) chk("i_rdata", bus.i_rdata, 16'hFFDF);
      if (c == 15) drop_all();
      if (c == 16) chk("busy_idle", bus.busy, 0);
    end
    chk("num_conflicts", bus.num_conflicts, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
